// File: rtl/qcs_gpio_evt_pkg.sv
// GPIO edge-event arbiter shared types.
// Width limit, event type, arbiter state and event bundle.
package qcs_gpio_evt_pkg;

  localparam int QCS_GPIO_EVT_MAX_WIDTH = 32;

  typedef enum logic {
    EVT_RISE = 1'b0,
    EVT_FALL = 1'b1
  } evt_type_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // idx sized for the widest legal pin count
  typedef struct packed {
    logic [4:0] idx;
    evt_type_e  etype;
  } evt_t;

endpackage

// File: rtl/qcs_gpio_rr_arb.sv
// Combinational round-robin find-first from ptr with an exclude mask.
// Ports: req, ptr, excl in; gnt_idx, gnt_vld out.
module qcs_gpio_rr_arb
  import qcs_gpio_evt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  input  logic [WIDTH-1:0] excl,
  output logic [IDXW-1:0]  gnt_idx,
  output logic             gnt_vld
);

  logic [IDXW:0] j;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int k = 0; k < WIDTH; k++) begin
      j = {1'b0, ptr} + (IDXW+1)'(k);
      if (j >= (IDXW+1)'(WIDTH)) begin
        j = j - (IDXW+1)'(WIDTH);
      end
      if (!gnt_vld && req[j[IDXW-1:0]] && !excl[j[IDXW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = j[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/qcs_gpio_evt_arb.sv
// GPIO edge detector with per-pin pending rise/fall and round-robin event output.
// Ports: clk, rst_n, gpio_i, rise/fall_en_i, evt valid/ready/idx/type, pend_o, ovf_o, ovf_clr_i. Option: QCS_GPIO_EVT_ARB_OVF_EN.
module qcs_gpio_evt_arb
  import qcs_gpio_evt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDXW-1:0]  evt_idx_o,
  output logic             evt_type_o,
  output logic [WIDTH-1:0] pend_o,
  output logic [WIDTH-1:0] ovf_o,
  input  logic [WIDTH-1:0] ovf_clr_i
);

  if (WIDTH < 1 || WIDTH > QCS_GPIO_EVT_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "qcs_gpio_evt_arb: WIDTH out of range 1..32");
  end

  logic [WIDTH-1:0] sync1, sync2, prev;
  logic [1:0]       arm;
  logic             arm_done;
  logic [WIDTH-1:0] rp, fp, ff;
  arb_state_e       state;
  evt_t             evt_q;
  logic [IDXW-1:0]  ptr;

  logic             acc;
  logic [IDXW-1:0]  cur_idx, nptr, arb_ptr;
  logic [WIDTH-1:0] sel, excl, clr_r, clr_f;
  logic [WIDTH-1:0] rise_det, fall_det;
  logic [WIDTH-1:0] rp_keep, fp_keep, rp_n, fp_n;
  logic [WIDTH-1:0] rise_new, fall_new, ff_n;
  logic [IDXW-1:0]  gnt_idx;
  logic             gnt_vld;
  evt_type_e        gnt_type;
  logic             unused_evt_idx;

  assign arm_done = (arm == 2'd3);
  assign cur_idx  = evt_q.idx[IDXW-1:0];
  assign unused_evt_idx = ^evt_q.idx;

  always_comb begin
    acc  = (state == ARB_HOLD) && evt_ready_i;
    sel  = '0;
    sel[cur_idx] = 1'b1;
    clr_r = (acc && evt_q.etype == EVT_RISE) ? sel : '0;
    clr_f = (acc && evt_q.etype == EVT_FALL) ? sel : '0;
    nptr  = (cur_idx == IDXW'(WIDTH-1)) ? '0 : cur_idx + 1'b1;
    arb_ptr = acc ? nptr : ptr;
    excl    = acc ? sel : '0;

    rise_det = {WIDTH{arm_done}} & sync2 & ~prev & rise_en_i;
    fall_det = {WIDTH{arm_done}} & ~sync2 & prev & fall_en_i;
    rp_keep  = rp & ~clr_r;
    fp_keep  = fp & ~clr_f;
    rp_n     = rp_keep | rise_det;
    fp_n     = fp_keep | fall_det;
    rise_new = rise_det & ~rp_keep;
    fall_new = fall_det & ~fp_keep;
    // ff=1 means fall is the older of the two pending edges
    ff_n = (fp_n & ~rp_n)
         | (fp_n & rp_n & (rise_new | (~fall_new & ff)));
  end

  qcs_gpio_rr_arb #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_rr (
    .req     (rp | fp),
    .ptr     (arb_ptr),
    .excl    (excl),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign gnt_type = (fp[gnt_idx] && (ff[gnt_idx] || !rp[gnt_idx]))
                  ? EVT_FALL : EVT_RISE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      arm   <= '0;
      rp    <= '0;
      fp    <= '0;
      ff    <= '0;
      state <= ARB_IDLE;
      evt_q <= '0;
      ptr   <= '0;
    end else begin
      sync1 <= gpio_i;
      sync2 <= sync1;
      prev  <= sync2;
      if (!arm_done) arm <= arm + 2'd1;
      rp <= rp_n;
      fp <= fp_n;
      ff <= ff_n;
      case (state)
        ARB_IDLE: begin
          if (gnt_vld) begin
            state <= ARB_HOLD;
            evt_q <= '{idx: 5'(gnt_idx), etype: gnt_type};
          end
        end
        ARB_HOLD: begin
          if (evt_ready_i) begin
            ptr <= nptr;
            if (gnt_vld) begin
              evt_q <= '{idx: 5'(gnt_idx), etype: gnt_type};
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign evt_valid_o = (state == ARB_HOLD);
  assign evt_idx_o   = cur_idx;
  assign evt_type_o  = evt_q.etype;
  assign pend_o      = rp | fp;

`ifdef QCS_GPIO_EVT_ARB_OVF_EN
  logic [WIDTH-1:0] ovf_q;
  logic [WIDTH-1:0] ovf_set;

  assign ovf_set = (rise_det & rp_keep) | (fall_det & fp_keep);

  // a new overflow in the clear cycle survives the clear
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= (ovf_q & ~ovf_clr_i) | ovf_set;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^ovf_clr_i;
  assign ovf_o = '0;
`endif

endmodule
